usb_setup_decoder: RTL

USB_SETUP_DECODER -- requirements
Module: usb_setup_decoder

---
 rtl/usb_setup_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/usb_setup_decoder.sv
// usb_setup_decoder
//   Collects the 8-byte USB SETUP payload, rejects packets of the wrong length,
//   checks standard requests for Request Error conditions and hands the
//   decoded request to a consumer with a valid/ready handshake.
//
// Ports
//   clk12        in   12 MHz clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   rxValid      in   payload byte present on rxData
//   rxData[7:0]  in   payload byte, byte 0 first
//   rxLast       in   last byte of the packet (qualified by rxValid)
//   rxReady      out  byte accepted when rxValid && rxReady
//   deviceState  in   0=reset, 1=address assigned, 2=configured, 3=treated as 0
//   setupPacket  out  assembled packet, byte k at bits [8k+7:8k]
//   reqValid     out  decoded request available
//   reqReady     in   consumer takes the request
//   reqStandard  out  request type is Standard
//   reqError     out  Request Error (answer with STALL), valid with reqValid
//   lenError     out  one-cycle pulse: a packet of length != 8 was discarded
module usb_setup_decoder #(
   parameter int NUM_INTERFACES         = 1,
   parameter int NUM_ENDPOINTS          = 4,
   parameter int NUM_CONFIGS            = 1,
   parameter int SUPPORT_SET_DESCRIPTOR = 0
) (
   input  logic        clk12,
   input  logic        rst,
   input  logic        rxValid,
   input  logic [7:0]  rxData,
   input  logic        rxLast,
   output logic        rxReady,
   input  logic [1:0]  deviceState,
   output logic [63:0] setupPacket,
   output logic        reqValid,
   input  logic        reqReady,
   output logic        reqStandard,
   output logic        reqError,
   output logic        lenError
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_DROP    = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;

   logic [2:0]  state_r;
   logic [2:0]  cnt_r;
   logic [63:0] pkt_r;
   logic        req_valid_r;
   logic        req_error_r;
   logic        req_standard_r;
   logic        len_error_r;
   logic        accept_s;
   logic        is_standard_s;
   logic        std_error_s;

   // Request Error rules for a standard request.
   function automatic logic std_request_error(
      input logic        dir_in,
      input logic [4:0]  recip,
      input logic [7:0]  breq,
      input logic [15:0] wvalue,
      input logic [7:0]  windex,
      input logic [1:0]  dev_state
   );
      logic [1:0] ds;
      logic       in_req;
      logic       err;
      ds     = (dev_state == 2'd3) ? 2'd0 : dev_state;
      // GET_STATUS, GET_DESCRIPTOR, GET_CONFIGURATION, GET_INTERFACE, SYNCH_FRAME
      in_req = (breq == 8'd0) || (breq == 8'd6) || (breq == 8'd8) ||
               (breq == 8'd10) || (breq == 8'd12);
      err = (breq == 8'd2) || (breq == 8'd4) || (breq >= 8'd13);
      err = err || (recip >= 5'd3);
      err = err || (in_req ? !dir_in : dir_in);
      err = err || ((recip == 5'd1) && ({1'b0, windex} >= 9'(NUM_INTERFACES)));
      err = err || ((recip == 5'd2) &&
                    (({1'b0, windex[3:0]} >= 5'(NUM_ENDPOINTS)) || (windex[6:4] != 3'd0)));
      // Address state: only index 0 may be addressed; bit 7 is the EP direction.
      err = err || ((ds == 2'd1) &&
                    (((recip == 5'd1) && (windex != 8'd0)) ||
                     ((recip == 5'd2) && (windex[6:0] != 7'd0))));
      err = err || (((breq == 8'd10) || (breq == 8'd11) || (breq == 8'd12)) && (ds != 2'd2));
      err = err || ((breq == 8'd9) &&
                    ((wvalue[15:8] != 8'd0) || ({1'b0, wvalue[7:0]} > 9'(NUM_CONFIGS))));
      err = err || ((breq == 8'd5) && (wvalue > 16'd127));
      err = err || ((breq == 8'd7) && (SUPPORT_SET_DESCRIPTOR == 0));
      // TEST_MODE cannot be cleared
      err = err || ((breq == 8'd1) && (wvalue == 16'd2));
      return err;
   endfunction

   assign rxReady     = (state_r == S_IDLE) || (state_r == S_COLLECT) || (state_r == S_DROP);
   assign accept_s    = rxValid && rxReady;
   assign setupPacket = pkt_r;
   assign reqValid    = req_valid_r;
   assign reqError    = req_error_r;
   assign reqStandard = req_standard_r;
   assign lenError    = len_error_r;

   // Decode of the collected packet, consumed only while in CHECK.
   always_comb begin
      is_standard_s = (pkt_r[6:5] == 2'b00);
      if (is_standard_s) begin
         std_error_s = std_request_error(pkt_r[7], pkt_r[4:0], pkt_r[15:8],
                                         pkt_r[31:16], pkt_r[39:32], deviceState);
      end else begin
         std_error_s = 1'b0;
      end
   end

   // Packet collection, length checking and request handshake state machine.
   always_ff @(posedge clk12) begin
      if (rst) begin
         state_r        <= S_IDLE;
         cnt_r          <= 3'd0;
         pkt_r          <= 64'd0;
         req_valid_r    <= 1'b0;
         req_error_r    <= 1'b0;
         req_standard_r <= 1'b0;
         len_error_r    <= 1'b0;
      end else begin
         len_error_r <= 1'b0;
         case (state_r)
            S_IDLE, S_COLLECT: begin
               if (accept_s) begin
                  pkt_r[{cnt_r, 3'b000} +: 8] <= rxData;
                  if (rxLast) begin
                     cnt_r <= 3'd0;
                     if (cnt_r == 3'd7) begin
                        state_r <= S_CHECK;
                     end else begin
                        len_error_r <= 1'b1;
                        state_r     <= S_IDLE;
                     end
                  end else if (cnt_r == 3'd7) begin
                     // Packet is longer than 8 bytes: swallow the remainder.
                     cnt_r   <= 3'd0;
                     state_r <= S_DROP;
                  end else begin
                     cnt_r   <= cnt_r + 3'd1;
                     state_r <= S_COLLECT;
                  end
               end
            end
            S_DROP: begin
               if (accept_s && rxLast) begin
                  len_error_r <= 1'b1;
                  state_r     <= S_IDLE;
               end
            end
            S_CHECK: begin
               // deviceState is sampled here only; the held result is frozen.
               req_error_r    <= std_error_s;
               req_standard_r <= is_standard_s;
               req_valid_r    <= 1'b1;
               state_r        <= S_HOLD;
            end
            S_HOLD: begin
               if (reqReady) begin
                  req_valid_r    <= 1'b0;
                  req_error_r    <= 1'b0;
                  req_standard_r <= 1'b0;
                  state_r        <= S_IDLE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               cnt_r       <= 3'd0;
               req_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
